// File: rtl/vertex_pkg.sv
// Shared opcode, ALUOp, branch funct3 and ALU-function definitions for the
// vertex execute stage.
package vertex_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_fn_e;

  // alt is funct7[5]; it selects sub only for register-register ops, sra for both.
  function automatic alu_fn_e alu_decode(input logic [1:0] alu_op,
                                         input logic [2:0] f3,
                                         input logic       alt);
    alu_fn_e fn;
    fn = ALU_ADD;
    case (alu_op)
      ALUOP_BRANCH: fn = ALU_SUB;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (f3)
          3'b000:  fn = (alt && (alu_op == ALUOP_RTYPE)) ? ALU_SUB : ALU_ADD;
          3'b001:  fn = ALU_SLL;
          3'b010:  fn = ALU_SLT;
          3'b011:  fn = ALU_SLTU;
          3'b100:  fn = ALU_XOR;
          3'b101:  fn = alt ? ALU_SRA : ALU_SRL;
          3'b110:  fn = ALU_OR;
          default: fn = ALU_AND;
        endcase
      end
      default: fn = ALU_ADD;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU for the execute stage.
module ex_alu
  import vertex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_fn_e         fn,
  output logic [XLEN-1:0] result
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic [4:0]             shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (fn)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned(a_s >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem.sv
// Execute stage and EX/MEM pipeline register: ALU, branch/jump resolution,
// one-cycle PC redirect and squash of the single wrong-path instruction.
module ex_mem
  import vertex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [6:0]      opcode_i,
  input  logic [4:0]      rd_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic            alu_src1_i,
  input  logic            alu_src2_i,
  input  logic [1:0]      alu_op_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            mem_to_reg_i,
  input  logic            reg_write_i,
  input  logic            is_branch_i,
  output logic            valid_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            reg_write_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  logic [XLEN-1:0]        op_a, op_b, alu_out, ex_result;
  logic [XLEN-1:0]        pc_target, jalr_sum, tgt;
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  alu_fn_e                alu_fn;
  logic                   is_jal, is_jalr, br_cond, accept, live, taken;
  logic                   kill_q;
  logic                   unused_f7;

  logic                   vld_p1, redirect_p1;
  logic                   mem_read_p1, mem_write_p1, mem_to_reg_p1, reg_write_p1;
  logic [XLEN-1:0]        alu_result_p1, store_data_p1, redirect_pc_p1;
  logic [4:0]             rd_p1;
  logic [2:0]             funct3_p1;

  assign unused_f7 = ^{funct7_i[6], funct7_i[4:0]};

  assign op_a   = alu_src1_i ? pc_i : rs1_val_i;
  assign op_b   = alu_src2_i ? imm_i : rs2_val_i;
  assign alu_fn = alu_decode(alu_op_i, funct3_i, funct7_i[5]);

  ex_alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .fn     (alu_fn),
    .result (alu_out)
  );

  assign is_jal  = (opcode_i == OP_JAL);
  assign is_jalr = (opcode_i == OP_JALR);
  assign rs1_s   = rs1_val_i;
  assign rs2_s   = rs2_val_i;

  always_comb begin
    br_cond = 1'b0;
    case (funct3_i)
      F3_BEQ:  br_cond = (rs1_val_i == rs2_val_i);
      F3_BNE:  br_cond = (rs1_val_i != rs2_val_i);
      F3_BLT:  br_cond = (rs1_s < rs2_s);
      F3_BGE:  br_cond = (rs1_s >= rs2_s);
      F3_BLTU: br_cond = (rs1_val_i < rs2_val_i);
      F3_BGEU: br_cond = (rs1_val_i >= rs2_val_i);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    ex_result = alu_out;
    if (opcode_i == OP_LUI)    ex_result = imm_i;
    else if (is_jal || is_jalr) ex_result = pc_i + XLEN'(4);
  end

  assign pc_target = pc_i + imm_i;
  assign jalr_sum  = rs1_val_i + imm_i;
  assign tgt       = is_jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : pc_target;

  // An accepted instruction arriving while kill_q is set is the wrong-path slot.
  assign accept = valid_i & ~stall_i & ~flush_i;
  assign live   = accept & ~kill_q;
  assign taken  = live & ((is_branch_i & br_cond) | is_jal | is_jalr);

  // EX -> MEM register boundary (p1)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1         <= 1'b0;
      redirect_p1    <= 1'b0;
      kill_q         <= 1'b0;
      mem_read_p1    <= 1'b0;
      mem_write_p1   <= 1'b0;
      mem_to_reg_p1  <= 1'b0;
      reg_write_p1   <= 1'b0;
      alu_result_p1  <= '0;
      store_data_p1  <= '0;
      redirect_pc_p1 <= '0;
      rd_p1          <= '0;
      funct3_p1      <= '0;
    end else if (flush_i) begin
      vld_p1        <= 1'b0;
      redirect_p1   <= 1'b0;
      kill_q        <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
    end else if (stall_i) begin
      redirect_p1 <= 1'b0;
    end else begin
      vld_p1         <= live;
      redirect_p1    <= taken;
      kill_q         <= valid_i ? taken : kill_q;
      mem_read_p1    <= live & mem_read_i;
      mem_write_p1   <= live & mem_write_i;
      mem_to_reg_p1  <= live & mem_to_reg_i;
      reg_write_p1   <= live & reg_write_i;
      alu_result_p1  <= ex_result;
      store_data_p1  <= rs2_val_i;
      redirect_pc_p1 <= tgt;
      rd_p1          <= rd_i;
      funct3_p1      <= funct3_i;
    end
  end

  assign valid_o       = vld_p1;
  assign redirect_o    = redirect_p1;
  assign redirect_pc_o = redirect_pc_p1;
  assign alu_result_o  = alu_result_p1;
  assign store_data_o  = store_data_p1;
  assign rd_o          = rd_p1;
  assign funct3_o      = funct3_p1;
  assign mem_read_o    = mem_read_p1;
  assign mem_write_o   = mem_write_p1;
  assign mem_to_reg_o  = mem_to_reg_p1;
  assign reg_write_o   = reg_write_p1;

endmodule
